// File: rtl/segment_writer_pkg.sv
// Shared constants and state encoding for the segment writer and its DMA write channel.
package segment_writer_pkg;

    localparam int unsigned NUM_SEGS  = 4;
    localparam int unsigned CL_BYTES  = 64;
    localparam int unsigned SEG_IDX_W = $clog2(NUM_SEGS);

    typedef enum logic [1:0] {
        SW_IDLE  = 2'd0,
        SW_WRITE = 2'd1,
        SW_DRAIN = 2'd2,
        SW_DONE  = 2'd3
    } sw_state_e;

endpackage

// File: rtl/segment_writer_if.sv
// DMA write channel bundle: request side (addr/data/en) toward the queue, full/ack back.
interface segment_writer_if
    import segment_writer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 512
) ();

    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  en;
    logic                  full;
    logic                  ack;

    modport master (output addr, data, en, input full, ack);
    modport slave  (input addr, data, en, output full, ack);

endinterface

// File: rtl/segment_writer.sv
// Writes NUM_SEGS segments of SEG_LINES cachelines to latched base addresses, then
// waits for every write ack before reporting done with the run's cycle count.
module segment_writer
    import segment_writer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned SEG_LINES  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] wr_addr_s0,
    input  logic [ADDR_WIDTH-1:0] wr_addr_s1,
    input  logic [ADDR_WIDTH-1:0] wr_addr_s2,
    input  logic [ADDR_WIDTH-1:0] wr_addr_s3,
    input  logic                  go,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] cv_value,
    output logic [ADDR_WIDTH-1:0] dma_wr_addr,
    output logic [DATA_WIDTH-1:0] dma_wr_data,
    output logic                  dma_wr_en,
    input  logic                  dma_wr_full,
    input  logic                  dma_wr_ack
);

    localparam int unsigned LINE_W = (SEG_LINES > 1) ? $clog2(SEG_LINES) : 1;
    localparam int unsigned OUT_W  = $clog2(NUM_SEGS * SEG_LINES + 1);

    localparam logic [1:0] S_IDLE  = 2'(SW_IDLE);
    localparam logic [1:0] S_WRITE = 2'(SW_WRITE);
    localparam logic [1:0] S_DRAIN = 2'(SW_DRAIN);
    localparam logic [1:0] S_DONE  = 2'(SW_DONE);

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [ADDR_WIDTH-1:0] base [NUM_SEGS];
    logic [SEG_IDX_W-1:0]  seg;
    logic [LINE_W-1:0]     line;
    logic [OUT_W-1:0]      outstanding;
    logic [OUT_W-1:0]      outstanding_next;
    logic                  accept;
    logic                  last_line;
    logic                  last_write;
    logic                  ack_take;
    logic                  go_take;

    // Write request and bookkeeping strobes
    always_comb begin
        dma_wr_en  = (state == S_WRITE) && !dma_wr_full;
        accept     = dma_wr_en;
        last_line  = (line == LINE_W'(SEG_LINES - 1));
        last_write = accept && last_line && (seg == SEG_IDX_W'(NUM_SEGS - 1));
        ack_take   = dma_wr_ack && (outstanding != '0);
        go_take    = go && ((state == S_IDLE) || (state == S_DONE));
    end

    // Outstanding count after this cycle's write/ack; acks with nothing in flight are dropped
    always_comb begin
        outstanding_next = outstanding;
        if (accept && !ack_take) begin
            outstanding_next = outstanding + OUT_W'(1);
        end else if (!accept && ack_take) begin
            outstanding_next = outstanding - OUT_W'(1);
        end
    end

    always_comb begin
        dma_wr_addr = base[seg] + (ADDR_WIDTH'(line) * ADDR_WIDTH'(CL_BYTES));
        dma_wr_data = '0;
        dma_wr_data[31:0]  = (32'(seg) * 32'(SEG_LINES)) + 32'(line);
        dma_wr_data[33:32] = seg;
    end

    // Next-state logic; DRAIN exits as soon as the last ack lands, even on its first cycle
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (go_take) state_next = S_WRITE;
            S_WRITE: if (last_write) state_next = S_DRAIN;
            S_DRAIN: if (outstanding_next == '0) state_next = S_DONE;
            S_DONE:  if (go_take) state_next = S_WRITE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done        <= 1'b0;
            cv_value    <= '0;
            seg         <= '0;
            line        <= '0;
            outstanding <= '0;
            for (int unsigned i = 0; i < NUM_SEGS; i++) begin
                base[i] <= '0;
            end
        end else begin
            done <= (state_next == S_DONE);
            if (go_take) begin
                base[0]     <= wr_addr_s0;
                base[1]     <= wr_addr_s1;
                base[2]     <= wr_addr_s2;
                base[3]     <= wr_addr_s3;
                cv_value    <= '0;
                seg         <= '0;
                line        <= '0;
                outstanding <= '0;
            end else begin
                outstanding <= outstanding_next;
                if (accept) begin
                    if (last_line) begin
                        line <= '0;
                        seg  <= seg + SEG_IDX_W'(1);
                    end else begin
                        line <= line + LINE_W'(1);
                    end
                end
                if (((state == S_WRITE) || (state == S_DRAIN)) && (cv_value != '1)) begin
                    cv_value <= cv_value + ADDR_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_segment_writer.sv
// Scoreboard bench: expected writes are queued at go, negedge monitors pop and compare.
module tb_segment_writer;
    import segment_writer_pkg::*;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 512;
    localparam int unsigned LA = 4;
    localparam int unsigned LB = 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          go_a, go_b;
    logic          done_a, done_b;
    logic [AW-1:0] cv_a, cv_b;
    logic [AW-1:0] sa [NUM_SEGS];
    logic [AW-1:0] sb [NUM_SEGS];

    wr_t qa[$];
    wr_t qb[$];
    wr_t wa, wb;
    int  total = 0;
    int  bad   = 0;
    int  wr_a  = 0;
    int  wr_b  = 0;
    int  ack_mode = 0;
    int  held  = 0;
    int  w0;
    logic pend_a = 1'b0;
    logic pend_b = 1'b0;

    always #5 clk = ~clk;

    segment_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dma_a ();
    segment_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dma_b ();

    segment_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEG_LINES(LA)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .wr_addr_s0(sa[0]), .wr_addr_s1(sa[1]), .wr_addr_s2(sa[2]), .wr_addr_s3(sa[3]),
        .go(go_a), .done(done_a), .cv_value(cv_a),
        .dma_wr_addr(dma_a.addr), .dma_wr_data(dma_a.data), .dma_wr_en(dma_a.en),
        .dma_wr_full(dma_a.full), .dma_wr_ack(dma_a.ack)
    );

    segment_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEG_LINES(LB)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wr_addr_s0(sb[0]), .wr_addr_s1(sb[1]), .wr_addr_s2(sb[2]), .wr_addr_s3(sb[3]),
        .go(go_b), .done(done_b), .cv_value(cv_b),
        .dma_wr_addr(dma_b.addr), .dma_wr_data(dma_b.data), .dma_wr_en(dma_b.en),
        .dma_wr_full(dma_b.full), .dma_wr_ack(dma_b.ack)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic wr_t mk(input logic [AW-1:0] b, input int seg, input int line, input int lines);
        wr_t w;
        w.addr = b + AW'(64 * line);
        w.data = '0;
        w.data[31:0]  = 32'(seg * lines + line);
        w.data[33:32] = 2'(seg);
        return w;
    endfunction

    task automatic push_run_a();
        for (int s = 0; s < 4; s++)
            for (int l = 0; l < int'(LA); l++)
                qa.push_back(mk(sa[s], s, l, LA));
    endtask

    task automatic pulse_go(input int which);
        @(posedge clk);
        #1;
        if (which == 0) go_a = 1'b1; else go_b = 1'b1;
        @(posedge clk);
        #1;
        go_a = 1'b0;
        go_b = 1'b0;
    endtask

    task automatic wait_done(input int which, input string name);
        logic d;
        d = 1'b0;
        for (int i = 0; i < 300 && !d; i++) begin
            @(negedge clk);
            d = (which == 0) ? done_a : done_b;
        end
        chk({name, "_done"}, d, 1);
    endtask

    // Monitor A: every presented write is accepted (no backpressure while en=1)
    always @(negedge clk) begin
        pend_a = dma_a.en;
        if (dma_a.full === 1'b1) chk("stall_en", dma_a.en, 0);
        if (dma_a.en === 1'b1) begin
            wr_a++;
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_wr_a: got write at %0h expected none", dma_a.addr);
            end else begin
                wa = qa.pop_front();
                chk("addr_a", dma_a.addr, wa.addr);
                chk("data_a", dma_a.data, wa.data);
            end
        end
    end

    // Ack source A: 0 = one cycle after write, 1 = withhold, 2 = release held, 3 = stray every cycle
    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0: dma_a.ack = pend_a;
            1: begin
                dma_a.ack = 1'b0;
                if (pend_a) held++;
            end
            2: begin
                dma_a.ack = (held > 0);
                if (held > 0) held--;
            end
            default: dma_a.ack = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        pend_b = dma_b.en;
        if (dma_b.en === 1'b1) begin
            wr_b++;
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_wr_b: got write at %0h expected none", dma_b.addr);
            end else begin
                wb = qb.pop_front();
                chk("addr_b", dma_b.addr, wb.addr);
                chk("data_b", dma_b.data, wb.data);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        dma_b.ack = pend_b;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        go_a = 1'b0;
        go_b = 1'b0;
        dma_a.full = 1'b0;
        dma_b.full = 1'b0;
        sa = '{64'h0, 64'h0, 64'h0, 64'h0};
        sb = '{64'h100, 64'h200, 64'h300, 64'hFFFF_FFFF_FFFF_FFC0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_done", done_a, 0);
        chk("rst_cv", cv_a, 0);
        chk("rst_en", dma_a.en, 0);
        chk("rst_addr", dma_a.addr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic run: 16 writes, ack one cycle later
        sa = '{64'h1000, 64'h2000, 64'h3000, 64'h4000};
        push_run_a();
        pulse_go(0);
        wait_done(0, "basic");
        chk("basic_cv", cv_a, 17);
        chk("basic_q", qa.size(), 0);
        repeat (3) @(negedge clk);
        chk("hold_cv", cv_a, 17);
        chk("hold_done", done_a, 1);

        // Five-cycle stall in the middle of segment 1
        push_run_a();
        pulse_go(0);
        repeat (6) @(posedge clk);
        #1 dma_a.full = 1'b1;
        repeat (5) @(posedge clk);
        #1 dma_a.full = 1'b0;
        wait_done(0, "stall");
        chk("stall_cv", cv_a, 22);
        chk("stall_q", qa.size(), 0);

        // Withhold all acks, then release 16 back to back
        @(negedge clk);
        ack_mode = 1;
        w0 = wr_a;
        push_run_a();
        pulse_go(0);
        repeat (16) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("drain_hold", done_a, 0);
        end
        ack_mode = 2;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("drain_wait", done_a, 0);
        end
        @(negedge clk);
        chk("drain_done", done_a, 1);
        chk("drain_count", wr_a - w0, 16);
        chk("drain_q", qa.size(), 0);
        ack_mode = 0;

        // go during WRITE is ignored; go in DONE restarts
        push_run_a();
        pulse_go(0);
        repeat (5) @(posedge clk);
        pulse_go(0);
        wait_done(0, "regoa");
        chk("regoa_cv", cv_a, 17);
        chk("regoa_q", qa.size(), 0);
        push_run_a();
        pulse_go(0);
        @(negedge clk);
        chk("regob_done0", done_a, 0);
        chk("regob_cv0", cv_a, 0);
        wait_done(0, "regob");
        chk("regob_cv", cv_a, 17);

        // Reset mid-run after 7 writes, stray acks, then a clean run
        push_run_a();
        pulse_go(0);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        ack_mode = 3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mrst_done", done_a, 0);
        chk("mrst_cv", cv_a, 0);
        chk("mrst_en", dma_a.en, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        qa.delete();
        repeat (3) @(negedge clk);
        chk("stray_en", dma_a.en, 0);
        chk("stray_done", done_a, 0);
        chk("stray_cv", cv_a, 0);
        ack_mode = 0;
        w0 = wr_a;
        push_run_a();
        pulse_go(0);
        wait_done(0, "post");
        chk("post_cv", cv_a, 17);
        chk("post_count", wr_a - w0, 16);
        chk("post_q", qa.size(), 0);

        // SEG_LINES=2 with segment 3 base wrapping past the top of the address space
        for (int s = 0; s < 3; s++)
            for (int l = 0; l < int'(LB); l++)
                qb.push_back(mk(sb[s], s, l, LB));
        wb.addr = 64'hFFFF_FFFF_FFFF_FFC0;
        wb.data = '0;
        wb.data[31:0] = 32'd6;
        wb.data[33:32] = 2'd3;
        qb.push_back(wb);
        wb.addr = 64'h0;
        wb.data[31:0] = 32'd7;
        qb.push_back(wb);
        pulse_go(1);
        wait_done(1, "wrap");
        chk("wrap_cv", cv_b, 9);
        chk("wrap_count", wr_b, 8);
        chk("wrap_q", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/segment_writer.md
SEGMENT_WRITER -- requirements
Module: segment_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, byte-address width, equal to the memory map's ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 512, cacheline width in bits.
REQ-003 SHALL have parameter SEG_LINES, default 16, cachelines written per segment; legal range 1..2^16.
REQ-004 SHALL have port clk, input, 1, sole clock.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have ports wr_addr_s0..wr_addr_s3, input, ADDR_WIDTH each, segment base byte addresses from the memory map.
REQ-007 SHALL have port go, input, 1, single-cycle start pulse from the memory map.
REQ-008 SHALL have port done, output, 1, level, high when a run has completed.
REQ-009 SHALL have port cv_value, output, ADDR_WIDTH, cycle count of the last or current run.
REQ-010 SHALL have port dma_wr_addr, output, ADDR_WIDTH, byte address of the current write.
REQ-011 SHALL have port dma_wr_data, output, DATA_WIDTH, write payload.
REQ-012 SHALL have port dma_wr_en, output, 1, write request valid.
REQ-013 SHALL have port dma_wr_full, input, 1, DMA write queue full.
REQ-014 SHALL have port dma_wr_ack, input, 1, one-cycle pulse per completed write.

Function
REQ-015 SHALL implement states IDLE, WRITE, DRAIN, DONE.
REQ-016 SHALL leave IDLE or DONE for WRITE on the edge where go=1, latching all four base addresses, clearing done, clearing cv_value, and zeroing the segment/line counters and the outstanding counter.
REQ-017 SHALL ignore go while in WRITE or DRAIN.
REQ-018 SHALL, in WRITE, drive dma_wr_en=1 combinationally only when dma_wr_full=0; a write is accepted on any cycle with dma_wr_en=1.
REQ-019 SHALL drive dma_wr_addr = latched base[seg] + 64*line, where seg is in 0..3 and line is in 0..SEG_LINES-1; the addition wraps modulo 2^ADDR_WIDTH.
REQ-020 SHALL drive dma_wr_data[31:0] = seg*SEG_LINES+line, dma_wr_data[33:32] = seg, and all other bits 0.
REQ-021 SHALL, on each accepted write, increment line; when line wraps from SEG_LINES-1 to 0, seg SHALL increment.
REQ-022 SHALL issue segments in order s0, s1, s2, s3 with no idle cycle between segments unless dma_wr_full=1.
REQ-023 SHALL move to DRAIN on the cycle after the last accepted write (seg=3, line=SEG_LINES-1).
REQ-024 SHALL maintain an outstanding counter: +1 on an accepted write, -1 on dma_wr_ack, unchanged when both occur in the same cycle; its width is clog2(4*SEG_LINES+1).
REQ-025 SHALL ignore dma_wr_ack when the outstanding counter is 0 (no underflow).
REQ-026 SHALL move from DRAIN to DONE when the outstanding counter is 0, including on the first DRAIN cycle.
REQ-027 SHALL hold done=1 throughout DONE; the transition DONE->WRITE on go SHALL clear done in the same edge.
REQ-028 SHALL increment cv_value on every cycle spent in WRITE or DRAIN, saturating at all-ones, and SHALL hold it in DONE and IDLE.
REQ-029 SHALL keep dma_wr_en=0 in IDLE, DRAIN and DONE.

Reset
REQ-030 SHALL, on a clk edge with rst_n=0, set state=IDLE, done=0, cv_value=0, and all counters and latched addresses to 0.
REQ-031 SHALL, on reset mid-run, discard outstanding acks; acks arriving after reset SHALL have no effect.

Structure
REQ-032 SHALL place the state enum, NUM_SEGS=4 and CL_BYTES=64 in a shared package, segment_writer_pkg.
REQ-033 SHALL be a single module with no sub-modules; the memory map instantiates alongside it and wires go, done, cv_value and wr_addr_s0..s3 directly.

Verification
REQ-034 With SEG_LINES=4, bases 0x1000/0x2000/0x3000/0x4000, full=0, and ack one cycle after each write: go -> 16 writes at 0x1000..0x10C0, 0x2000..0x20C0, and so on with data 0..15; done=1 with cv_value=17.
REQ-035 With full=1 for 5 cycles mid-segment 1: no writes during the stall, order preserved, and cv_value=22.
REQ-036 With all acks withheld until 10 cycles after the last write: DRAIN holds, done rises one cycle after the final ack, and 0 writes are lost.
REQ-037 With go pulsed during WRITE: no restart and an identical write stream; a second go in DONE starts a new run with done=0 on the next cycle.
REQ-038 With rst_n=0 after 7 writes followed by stray acks: state=IDLE, done=0, cv_value=0, and a subsequent go produces 16 clean writes.
REQ-039 With base s3=0xFFFF_FFFF_FFFF_FFC0 and SEG_LINES=2: s3 addresses are 0x...FFC0 then 0x0000 (wrap).
